// File: rtl/regfile_mp_if.sv
// Register file bus: read/write ports, scoreboard alloc and
// exception capture signals between decode, writeback and regfile.
interface regfile_mp_if #(
  parameter int DATA_W = 16,
  parameter int AW     = 3,
  parameter int NUM_RD = 3,
  parameter int NUM_WR = 2
);
  logic                     rd_en;
  logic [NUM_RD*AW-1:0]     rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*AW-1:0]     wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic [NUM_WR-1:0]        wr_ack;
  logic                     wr_conflict;
  logic                     alloc_en;
  logic [AW-1:0]            alloc_addr;
  logic                     excep;
  logic [DATA_W-1:0]        excep_pc;
  logic [3:0]               excep_cause;
  logic                     eret;
  logic [DATA_W-1:0]        epc;
  logic [3:0]               ecause;
  logic                     epc_valid;
  logic                     excep_ovf;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output alloc_en, alloc_addr,
    output excep, excep_pc, excep_cause, eret,
    input  rd_data, rd_busy, wr_ack, wr_conflict,
    input  epc, ecause, epc_valid, excep_ovf
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  alloc_en, alloc_addr,
    input  excep, excep_pc, excep_cause, eret,
    output rd_data, rd_busy, wr_ack, wr_conflict,
    output epc, ecause, epc_valid, excep_ovf
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with write bypass, pending-result
// scoreboard and single-entry exception capture (EPC/cause).
module regfile_mp #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int NUM_RD   = 3,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_R0  = 0
) (
  input logic         clk,
  input logic         rst_n,
  regfile_mp_if.slave bus
);
  localparam int AW = $clog2(NUM_REGS);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]             busy_q, busy_d;
  logic [NUM_WR-1:0]               wr_ack_q, wr_ack_d;
  logic                            conflict_q, conflict_d;
  logic [DATA_W-1:0]               epc_q, epc_d;
  logic [3:0]                      ecause_q, ecause_d;
  logic                            epc_valid_q, epc_valid_d;
  logic                            ovf_q, ovf_d;

  logic [AW-1:0]                   wa;
  logic [AW-1:0]                   ra;
  logic [DATA_W-1:0]               rv;
  logic                            hit;
  logic [NUM_RD*DATA_W-1:0]        rd_data;
  logic [NUM_RD-1:0]               rd_busy;

  // Later ports overwrite earlier ones, so the highest index wins
  always_comb begin
    regs_d     = regs_q;
    busy_d     = busy_q;
    conflict_d = 1'b0;
    wa         = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      wa = bus.wr_addr[i*AW +: AW];
      if (bus.wr_en[i]) begin
        busy_d[wa] = 1'b0;
        if (!(ZERO_R0 != 0 && wa == '0))
          regs_d[wa] = bus.wr_data[i*DATA_W +: DATA_W];
        for (int j = i + 1; j < NUM_WR; j++)
          if (bus.wr_en[j] &&
              bus.wr_addr[j*AW +: AW] == wa)
            conflict_d = 1'b1;
      end
    end
    if (bus.alloc_en)
      busy_d[bus.alloc_addr] = 1'b1;
    if (ZERO_R0 != 0)
      busy_d[0] = 1'b0;
  end

  always_comb begin
    wr_ack_d = bus.wr_en;
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    rv      = '0;
    hit     = 1'b0;
    for (int r = 0; r < NUM_RD; r++) begin
      ra  = bus.rd_addr[r*AW +: AW];
      rv  = regs_q[ra];
      hit = 1'b0;
      if (BYPASS != 0)
        for (int w = 0; w < NUM_WR; w++)
          if (bus.wr_en[w] &&
              bus.wr_addr[w*AW +: AW] == ra) begin
            hit = 1'b1;
            rv  = bus.wr_data[w*DATA_W +: DATA_W];
          end
      if (ZERO_R0 != 0 && ra == '0)
        rv = '0;
      if (bus.rd_en) begin
        rd_data[r*DATA_W +: DATA_W] = rv;
        rd_busy[r] = busy_q[ra] & ~hit;
      end
    end
  end

  always_comb begin
    epc_d       = epc_q;
    ecause_d    = ecause_q;
    epc_valid_d = epc_valid_q;
    ovf_d       = ovf_q;
    unique case (1'b1)
      bus.excep && bus.eret: begin
        epc_d       = bus.excep_pc;
        ecause_d    = bus.excep_cause;
        epc_valid_d = 1'b1;
        ovf_d       = 1'b0;
      end
      bus.excep && !bus.eret && !epc_valid_q: begin
        epc_d       = bus.excep_pc;
        ecause_d    = bus.excep_cause;
        epc_valid_d = 1'b1;
      end
      bus.excep && !bus.eret && epc_valid_q: begin
        ovf_d = 1'b1;
      end
      !bus.excep && bus.eret: begin
        epc_valid_d = 1'b0;
        ovf_d       = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q      <= '0;
      busy_q      <= '0;
      wr_ack_q    <= '0;
      conflict_q  <= 1'b0;
      epc_q       <= '0;
      ecause_q    <= '0;
      epc_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      busy_q      <= busy_d;
      wr_ack_q    <= wr_ack_d;
      conflict_q  <= conflict_d;
      epc_q       <= epc_d;
      ecause_q    <= ecause_d;
      epc_valid_q <= epc_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.rd_data     = rd_data;
  assign bus.rd_busy     = rd_busy;
  assign bus.wr_ack      = wr_ack_q;
  assign bus.wr_conflict = conflict_q;
  assign bus.epc         = epc_q;
  assign bus.ecause      = ecause_q;
  assign bus.epc_valid   = epc_valid_q;
  assign bus.excep_ovf   = ovf_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two configurations (bypass / zero-r0)
// driven in lockstep and checked against an array-based model.
module tb_regfile_mp;
  logic clk;
  logic rst_n;

  logic        rd_en;
  logic [8:0]  rd_addr;
  logic [1:0]  wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic        alloc_en;
  logic [2:0]  alloc_addr;
  logic        excep;
  logic [15:0] excep_pc;
  logic [3:0]  excep_cause;
  logic        eret;

  regfile_mp_if #(.DATA_W(16), .AW(3), .NUM_RD(3), .NUM_WR(2)) b0 ();
  regfile_mp_if #(.DATA_W(16), .AW(3), .NUM_RD(3), .NUM_WR(2)) b1 ();

  assign b0.rd_en = rd_en;       assign b1.rd_en = rd_en;
  assign b0.rd_addr = rd_addr;   assign b1.rd_addr = rd_addr;
  assign b0.wr_en = wr_en;       assign b1.wr_en = wr_en;
  assign b0.wr_addr = wr_addr;   assign b1.wr_addr = wr_addr;
  assign b0.wr_data = wr_data;   assign b1.wr_data = wr_data;
  assign b0.alloc_en = alloc_en; assign b1.alloc_en = alloc_en;
  assign b0.alloc_addr = alloc_addr;
  assign b1.alloc_addr = alloc_addr;
  assign b0.excep = excep;       assign b1.excep = excep;
  assign b0.excep_pc = excep_pc; assign b1.excep_pc = excep_pc;
  assign b0.excep_cause = excep_cause;
  assign b1.excep_cause = excep_cause;
  assign b0.eret = eret;         assign b1.eret = eret;

  regfile_mp #(
    .DATA_W(16), .NUM_REGS(8), .NUM_RD(3), .NUM_WR(2),
    .BYPASS(1), .ZERO_R0(0)
  ) u_byp (.clk(clk), .rst_n(rst_n), .bus(b0));

  regfile_mp #(
    .DATA_W(16), .NUM_REGS(8), .NUM_RD(3), .NUM_WR(2),
    .BYPASS(0), .ZERO_R0(1)
  ) u_zr0 (.clk(clk), .rst_n(rst_n), .bus(b1));

  logic [47:0] o_rd_data [2];
  logic [2:0]  o_rd_busy [2];
  logic [1:0]  o_wr_ack  [2];
  logic        o_conf    [2];
  logic [15:0] o_epc     [2];
  logic [3:0]  o_ecause  [2];
  logic        o_ev      [2];
  logic        o_ovf     [2];

  assign o_rd_data[0] = b0.rd_data;  assign o_rd_data[1] = b1.rd_data;
  assign o_rd_busy[0] = b0.rd_busy;  assign o_rd_busy[1] = b1.rd_busy;
  assign o_wr_ack[0] = b0.wr_ack;    assign o_wr_ack[1] = b1.wr_ack;
  assign o_conf[0] = b0.wr_conflict; assign o_conf[1] = b1.wr_conflict;
  assign o_epc[0] = b0.epc;          assign o_epc[1] = b1.epc;
  assign o_ecause[0] = b0.ecause;    assign o_ecause[1] = b1.ecause;
  assign o_ev[0] = b0.epc_valid;     assign o_ev[1] = b1.epc_valid;
  assign o_ovf[0] = b0.excep_ovf;    assign o_ovf[1] = b1.excep_ovf;

  localparam bit BYP [2] = '{1'b1, 1'b0};
  localparam bit ZR  [2] = '{1'b0, 1'b1};

  logic [15:0] m_regs [2][8];
  logic        m_busy [2][8];
  logic [1:0]  m_ack;
  logic        m_conf;
  logic [15:0] m_epc;
  logic [3:0]  m_ecause;
  logic        m_ev;
  logic        m_ovf;

  int n_chk;
  int n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 8; a++) begin
        m_regs[d][a] = '0;
        m_busy[d][a] = 1'b0;
      end
    m_ack = '0; m_conf = 1'b0;
    m_epc = '0; m_ecause = '0;
    m_ev = 1'b0; m_ovf = 1'b0;
  endtask

  function automatic void exp_rd(int d, output logic [47:0] dat,
                                 output logic [2:0] bsy);
    logic [2:0]  a;
    logic [15:0] v;
    bit          h;
    dat = '0; bsy = '0;
    for (int r = 0; r < 3; r++) begin
      a = rd_addr[r*3 +: 3];
      v = m_regs[d][a];
      h = 1'b0;
      if (BYP[d])
        for (int w = 0; w < 2; w++)
          if (wr_en[w] && wr_addr[w*3 +: 3] == a) begin
            v = wr_data[w*16 +: 16];
            h = 1'b1;
          end
      if (ZR[d] && a == 3'd0) v = '0;
      if (rd_en) begin
        dat[r*16 +: 16] = v;
        bsy[r] = m_busy[d][a] && !h;
      end
    end
  endfunction

  task automatic model_update();
    logic [2:0] a;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 2; w++)
        if (wr_en[w]) begin
          a = wr_addr[w*3 +: 3];
          m_busy[d][a] = 1'b0;
          if (!(ZR[d] && a == 3'd0))
            m_regs[d][a] = wr_data[w*16 +: 16];
        end
      if (alloc_en && !(ZR[d] && alloc_addr == 3'd0))
        m_busy[d][alloc_addr] = 1'b1;
    end
    m_ack  = wr_en;
    m_conf = (&wr_en) && (wr_addr[2:0] == wr_addr[5:3]);
    if (excep) begin
      if (eret || !m_ev) begin
        m_epc = excep_pc; m_ecause = excep_cause; m_ev = 1'b1;
        if (eret) m_ovf = 1'b0;
      end else
        m_ovf = 1'b1;
    end else if (eret) begin
      m_ev = 1'b0; m_ovf = 1'b0;
    end
  endtask

  task automatic check_all();
    logic [47:0] ed;
    logic [2:0]  eb;
    for (int d = 0; d < 2; d++) begin
      exp_rd(d, ed, eb);
      check($sformatf("rd_data[u%0d]", d), 64'(o_rd_data[d]), 64'(ed));
      check($sformatf("rd_busy[u%0d]", d), 64'(o_rd_busy[d]), 64'(eb));
      check($sformatf("wr_ack[u%0d]", d), 64'(o_wr_ack[d]), 64'(m_ack));
      check($sformatf("wr_conflict[u%0d]", d), 64'(o_conf[d]), 64'(m_conf));
      check($sformatf("epc[u%0d]", d), 64'(o_epc[d]), 64'(m_epc));
      check($sformatf("ecause[u%0d]", d), 64'(o_ecause[d]), 64'(m_ecause));
      check($sformatf("epc_valid[u%0d]", d), 64'(o_ev[d]), 64'(m_ev));
      check($sformatf("excep_ovf[u%0d]", d), 64'(o_ovf[d]), 64'(m_ovf));
    end
  endtask

  // Called at a negedge with inputs already applied
  task automatic cycle();
    #1 check_all();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    rd_en = 1'b0; rd_addr = '0;
    wr_en = '0; wr_addr = '0; wr_data = '0;
    alloc_en = 1'b0; alloc_addr = '0;
    excep = 1'b0; excep_pc = '0; excep_cause = '0; eret = 1'b0;
  endtask

  function automatic logic [2:0] pick();
    if ($urandom_range(0, 1) == 1) return 3'($urandom_range(0, 2));
    return 3'($urandom_range(0, 7));
  endfunction

  task automatic rand_in();
    rd_en = ($urandom_range(0, 4) != 0);
    for (int r = 0; r < 3; r++) rd_addr[r*3 +: 3] = pick();
    wr_en = 2'($urandom);
    wr_addr = {pick(), pick()};
    wr_data = $urandom;
    alloc_en = 1'($urandom);
    alloc_addr = pick();
    excep = ($urandom_range(0, 4) == 0);
    eret = ($urandom_range(0, 5) == 0);
    excep_pc = 16'($urandom);
    excep_cause = 4'($urandom);
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst_n = 1'b0;
    idle();
    model_reset();
    @(negedge clk);
    cycle();
    rst_n = 1'b1;

    // write R3 with same-cycle read, then read again
    idle(); rd_en = 1'b1; rd_addr = 9'd3;
    wr_en = 2'b01; wr_addr = 6'd3; wr_data = 32'h0000_BEEF;
    #1 check("byp_r3", 64'(o_rd_data[0][15:0]), 64'h BEEF);
    cycle();
    idle(); rd_en = 1'b1; rd_addr = 9'd3;
    cycle();

    // both ports hit R5
    idle(); rd_en = 1'b1; rd_addr = {3'd5, 3'd5, 3'd5};
    wr_en = 2'b11; wr_addr = {3'd5, 3'd5};
    wr_data = {16'h2222, 16'h1111};
    #1 check("byp_r5", 64'(o_rd_data[0][15:0]), 64'h2222);
    cycle();
    idle(); rd_en = 1'b1; rd_addr = 9'd5;
    #1 check("conf_r5", 64'(o_conf[0]), 64'd1);
    cycle();
    idle(); cycle();

    // scoreboard on R2
    idle(); alloc_en = 1'b1; alloc_addr = 3'd2;
    rd_en = 1'b1; rd_addr = 9'd2;
    cycle();
    alloc_en = 1'b1; wr_en = 2'b01; wr_addr = 6'd2;
    wr_data = 32'h0000_0042;
    cycle();
    idle(); rd_en = 1'b1; rd_addr = 9'd2;
    #1 check("busy_r2", 64'(o_rd_busy[1][0]), 64'd1);
    check("data_r2", 64'(o_rd_data[1][15:0]), 64'h0042);
    cycle();
    wr_en = 2'b10; wr_addr = {3'd2, 3'd0}; wr_data = 32'h0007_0000;
    cycle();
    idle(); rd_en = 1'b1; rd_addr = 9'd2; cycle();

    // R0 writes/allocs
    idle(); rd_en = 1'b1; rd_addr = 9'd0;
    wr_en = 2'b01; wr_data = 32'h0000_FFFF;
    alloc_en = 1'b1; alloc_addr = 3'd0;
    cycle();
    idle(); rd_en = 1'b1; rd_addr = 9'd0; cycle();

    // exception sequence
    idle(); excep = 1'b1; excep_pc = 16'h0100; excep_cause = 4'd3;
    cycle();
    idle(); excep = 1'b1; excep_pc = 16'h0200; excep_cause = 4'd5;
    cycle();
    idle(); eret = 1'b1; cycle();
    idle(); excep = 1'b1; eret = 1'b1;
    excep_pc = 16'h0300; excep_cause = 4'd1;
    cycle();
    idle();
    #1 check("epc_0300", 64'(o_epc[0]), 64'h0300);
    cycle();

    for (int k = 0; k < 400; k++) begin
      rand_in();
      cycle();
    end

    // asynchronous reset in the middle of a cycle
    idle(); rd_en = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    rd_addr = {3'd2, 3'd1, 3'd0};
    #1 check_all();
    rd_addr = {3'd5, 3'd4, 3'd3};
    #1 check_all();
    @(posedge clk);
    rd_addr = {3'd7, 3'd6, 3'd5};
    #1 check_all();
    rd_en = 1'b0;
    #1 check_all();
    @(negedge clk);
    rand_in();
    cycle();
    rst_n = 1'b1;

    for (int k = 0; k < 200; k++) begin
      rand_in();
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
